// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
// Also provides the counter width helper used by bit-period timers.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int IDX_W     = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   function automatic int bit_cnt_w(input int clks_per_bit);
      return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value lets idle-high lines (UART rx) come up idle.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, mid-bit sampling,
// one-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 17
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_error,
   output logic                 overrun
);

   localparam int CNT_W = bit_cnt_w(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   rx_state_t            state;
   rx_state_t            next_state;
   logic                 rs;
   logic [CNT_W-1:0]     bit_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift_reg;

   logic                 cnt_run;
   logic                 tick;
   logic                 shift_en;
   logic                 byte_done;
   logic                 stop_bad;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (rx),
      .q    (rs)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (!rs) begin
               next_state = START;
            end
         end
         START: begin
            if (tick) begin
               next_state = rs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && (bit_idx == IDX_LAST)) begin
               next_state = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               next_state = rs ? IDLE : WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (rs) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The start phase ends half a bit in, so later samples land mid-bit.
   always_comb begin
      cnt_run   = 1'b0;
      tick      = 1'b0;
      shift_en  = 1'b0;
      byte_done = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         START: begin
            cnt_run = 1'b1;
            tick    = (bit_cnt == HALF_LAST);
         end
         DATA: begin
            cnt_run  = 1'b1;
            tick     = (bit_cnt == BIT_LAST);
            shift_en = tick;
         end
         STOP: begin
            cnt_run   = 1'b1;
            tick      = (bit_cnt == BIT_LAST);
            byte_done = tick && rs;
            stop_bad  = tick && !rs;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         if (!cnt_run || tick) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == START) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 1'b1;
         end
         if (shift_en) begin
            shift_reg <= {rs, shift_reg[DATA_BITS-1:1]};
         end
      end
   end

   // A completing byte may replace the buffered one only if it is drained now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data        <= '0;
         valid       <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_error <= stop_bad;
         overrun     <= byte_done && valid && !ready;
         if (byte_done && (!valid || ready)) begin
            data  <= shift_reg;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven on rx and
// expected bytes are scoreboarded against the valid/ready handshake.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPB = 17;
   localparam int LAT = 164;

   typedef struct {
      logic [7:0] value;
      int         start_cyc;
      bit         check_lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_error;
   logic       overrun;

   int   cyc = 0;
   int   tests = 0;
   int   failures = 0;
   int   valid_hi = 0;
   int   fe_hi = 0;
   int   ov_hi = 0;
   int   fe_cyc = 0;
   int   last_start = 0;
   logic valid_d = 1'b0;
   exp_t sb_q[$];
   int   rise_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .frame_error(frame_error),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one full frame starting just after a clock edge.
   task automatic applyStimulus(input logic [7:0] value, input logic stop_bit,
                                input bit expect_byte, input bit check_lat);
      exp_t e;
      rx = 1'b0;
      last_start = cyc;
      if (expect_byte) begin
         e.value     = value;
         e.start_cyc = cyc;
         e.check_lat = check_lat;
         sb_q.push_back(e);
      end
      stepCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = value[i];
         stepCycles(CPB);
      end
      rx = stop_bit;
      stepCycles(CPB);
   endtask

   // Monitor samples on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      if (!reset) begin
         if (valid) valid_hi++;
         if (valid && !valid_d) rise_q.push_back(cyc);
         if (frame_error) begin
            fe_hi++;
            fe_cyc = cyc;
         end
         if (overrun) ov_hi++;
         if (valid && ready) begin
            if (sb_q.size() == 0) begin
               checkOutput("sb_unexpected_byte", 32'(data), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               checkOutput("data", 32'(data), 32'(e.value));
               if (e.check_lat) checkOutput("valid_latency", 32'(cyc - e.start_cyc), 32'(LAT));
            end
         end
         valid_d = valid;
      end
   end

   initial begin
      int b_v, b_fe, b_ov, b_rise, k;

      stepCycles(3);
      checkOutput("reset_data", 32'(data), 32'h0);
      checkOutput("reset_valid", 32'(valid), 32'h0);
      checkOutput("reset_fe", 32'(frame_error), 32'h0);
      checkOutput("reset_ov", 32'(overrun), 32'h0);
      checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0;
      stepCycles(10);

      $display("[TB] frame 0x55 with ready high");
      b_v = valid_hi; b_fe = fe_hi; b_ov = ov_hi;
      applyStimulus(8'h55, 1'b1, 1'b1, 1'b1);
      stepCycles(10);
      checkOutput("t1_valid_cycles", 32'(valid_hi - b_v), 32'd1);
      checkOutput("t1_no_fe", 32'(fe_hi - b_fe), 32'd0);
      checkOutput("t1_no_ov", 32'(ov_hi - b_ov), 32'd0);

      $display("[TB] overrun: 0xA3 held, 0x3C dropped");
      ready = 1'b0;
      b_ov = ov_hi; b_fe = fe_hi;
      applyStimulus(8'hA3, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
      stepCycles(2);
      checkOutput("t2_ov_cycles", 32'(ov_hi - b_ov), 32'd1);
      checkOutput("t2_no_fe", 32'(fe_hi - b_fe), 32'd0);
      checkOutput("t2_valid_held", 32'(valid), 32'd1);
      checkOutput("t2_data_held", 32'(data), 32'hA3);
      ready = 1'b1;
      stepCycles(1);
      checkOutput("t2_valid_dropped", 32'(valid), 32'd0);
      stepCycles(10);

      $display("[TB] 5-cycle glitch on rx");
      b_v = valid_hi; b_fe = fe_hi;
      rx = 1'b0;
      stepCycles(5);
      rx = 1'b1;
      stepCycles(4);
      checkOutput("t3_in_start", 32'(dut.state), 32'(START));
      stepCycles(2);
      checkOutput("t3_back_idle", 32'(dut.state), 32'(IDLE));
      stepCycles(20);
      checkOutput("t3_no_valid", 32'(valid_hi - b_v), 32'd0);
      checkOutput("t3_no_fe", 32'(fe_hi - b_fe), 32'd0);

      $display("[TB] bad stop bit on 0x81, then break");
      b_v = valid_hi; b_fe = fe_hi; b_ov = ov_hi;
      applyStimulus(8'h81, 1'b0, 1'b0, 1'b0);
      k = last_start;
      stepCycles(40);
      checkOutput("t4_wait_idle", 32'(dut.state), 32'(WAIT_IDLE));
      rx = 1'b1;
      stepCycles(20);
      checkOutput("t4_fe_cycles", 32'(fe_hi - b_fe), 32'd1);
      checkOutput("t4_fe_latency", 32'(fe_cyc - k), 32'(LAT));
      checkOutput("t4_no_valid", 32'(valid_hi - b_v), 32'd0);
      checkOutput("t4_no_ov", 32'(ov_hi - b_ov), 32'd0);
      applyStimulus(8'h7E, 1'b1, 1'b1, 1'b1);
      stepCycles(10);

      $display("[TB] back-to-back 0x00, 0xFF");
      b_rise = rise_q.size();
      applyStimulus(8'h00, 1'b1, 1'b1, 1'b1);
      applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
      stepCycles(10);
      checkOutput("t5_rise_count", 32'(rise_q.size() - b_rise), 32'd2);
      if (rise_q.size() >= b_rise + 2)
         checkOutput("t5_spacing", 32'(rise_q[b_rise+1] - rise_q[b_rise]), 32'(10 * CPB));

      $display("[TB] reset in the middle of 0x12");
      ready = 1'b0;
      applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);
      stepCycles(5);
      checkOutput("t6_pre_valid", 32'(valid), 32'd1);
      rx = 1'b0;
      stepCycles(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h12 >> i) & 8'h01;
         stepCycles(CPB);
      end
      rx = 1'b1;
      stepCycles(CPB / 2);
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_data", 32'(data), 32'h0);
      checkOutput("t6_rst_valid", 32'(valid), 32'h0);
      checkOutput("t6_rst_fe", 32'(frame_error), 32'h0);
      checkOutput("t6_rst_ov", 32'(overrun), 32'h0);
      checkOutput("t6_rst_state", 32'(dut.state), 32'(IDLE));
      sb_q.delete();
      stepCycles(3);
      reset = 1'b0;
      valid_d = 1'b0;
      stepCycles(20);
      ready = 1'b1;
      applyStimulus(8'h34, 1'b1, 1'b1, 1'b1);
      stepCycles(20);

      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
